// File: rtl/mcu_bus_pkg.sv
// Shared definitions for the MCU's 16-bit slave bus: widths, access polarity and RAM FSM states.
package mcu_bus_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWait,
    StAccess,
    StHold
  } ram_state_e;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous word array with registered read data.
module ram_array
  import mcu_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_slave.sv
// Data-RAM slave: decodes the BIU handshake, inserts wait states, flags out-of-range
// accesses and drives read data onto the shared bus only while holding a completed read.
module ram_slave
  import mcu_bus_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_ram,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  output logic              ready_ram,
  output logic              err
);

  localparam int unsigned AddrBits = $clog2(DEPTH);
  localparam logic [3:0]  WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  ram_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              mem_we, mem_re;
  logic              out_of_range;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] dout;

  assign out_of_range = (addr_q >> AddrBits) != '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    read_d  = read_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_ram) state_d = StSetup;
      end
      StSetup: begin
        if (!cs_ram) begin
          state_d = StIdle;
        end else begin
          // The BIU presents the address one cycle after cs_ram, so latch it here.
          addr_d = address;
          read_d = read;
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StWait: begin
        if (!cs_ram) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: begin
        state_d = StHold;
        if (out_of_range) begin
          err_d = 1'b1;
        end else if (read_q == BUS_READ) begin
          mem_re = 1'b1;
        end else begin
          mem_we = 1'b1;
        end
      end
      StHold: begin
        if (!cs_ram) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle) || (state_d == StHold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      read_q  <= BUS_WRITE;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Gating with rst drops a write whose ACCESS edge coincides with reset.
  ram_array #(
    .DEPTH(DEPTH)
  ) u_ram_array (
    .clk  (clk),
    .we   (mem_we && !rst),
    .re   (mem_re && !rst),
    .addr (addr_q[AddrBits-1:0]),
    .wdata(data),
    .rdata(rdata)
  );

  assign dout      = out_of_range ? '0 : rdata;
  assign data      = (state_q == StHold && read_q == BUS_READ && cs_ram) ? dout
                                                                         : {DATA_W{1'bz}};
  assign ready_ram = ready_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ram_slave.sv
// Self-checking bench: two ram_slave instances (2 and 0 wait states) against a transaction-level model.
module tb_ram_slave;

  logic        clk = 1'b0;
  logic        cs      [2];
  logic        rd      [2];
  logic        rst_v   [2];
  logic [15:0] addr    [2];
  logic        drv_en  [2];
  logic [15:0] drv_val [2];
  logic        rdy     [2];
  logic        errv    [2];
  wire  [15:0] bus_a;
  wire  [15:0] bus_b;

  logic        exp_rdy [2];
  logic        exp_err [2];
  logic        exp_drv [2];
  logic [15:0] exp_val [2];
  logic [15:0] mem_m   [2][32];
  logic        chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign bus_a = drv_en[0] ? drv_val[0] : 16'hzzzz;
  assign bus_b = drv_en[1] ? drv_val[1] : 16'hzzzz;

  // Undriven bus reads as all ones, which makes a released bus visible.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (bus_a[i]);
    pullup (bus_b[i]);
  end

  ram_slave #(.DEPTH(1024), .WAIT_STATES(2)) u_dut_w2 (
    .clk      (clk),
    .rst      (rst_v[0]),
    .cs_ram   (cs[0]),
    .read     (rd[0]),
    .address  (addr[0]),
    .data     (bus_a),
    .ready_ram(rdy[0]),
    .err      (errv[0])
  );

  ram_slave #(.DEPTH(1024), .WAIT_STATES(0)) u_dut_w0 (
    .clk      (clk),
    .rst      (rst_v[1]),
    .cs_ram   (cs[1]),
    .read     (rd[1]),
    .address  (addr[1]),
    .data     (bus_b),
    .ready_ram(rdy[1]),
    .err      (errv[1])
  );

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bus_of(input int u);
    return (u == 0) ? bus_a : bus_b;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        logic [15:0] eb;
        eb = exp_drv[u] ? exp_val[u] : (drv_en[u] ? drv_val[u] : 16'hFFFF);
        check(u == 0 ? "ready_w2" : "ready_w0", 16'(rdy[u]), 16'(exp_rdy[u]));
        check(u == 0 ? "err_w2" : "err_w0", 16'(errv[u]), 16'(exp_err[u]));
        check(u == 0 ? "bus_w2" : "bus_w0", bus_of(u), eb);
      end
    end
  end

  // One BIU transaction. Edge m=1 is the edge that first samples cs_ram; the access
  // completes on edge WAIT_STATES+3 and the bus is held for hold_n cycles after that.
  task automatic txn(input int u, input bit is_rd, input logic [15:0] a, input logic [15:0] wd,
                     input int abort_m, input bit rst_acc, input int hold_n,
                     output logic [15:0] got, output int lat, output int low_cnt);
    int  lw;
    bit  in_rng;
    lw      = ((u == 0) ? 2 : 0) + 2;
    in_rng  = (a < 16'd1024);
    got     = 16'h0000;
    lat     = -1;
    low_cnt = 0;
    @(posedge clk); #1;
    cs[u]      = 1'b1;
    rd[u]      = is_rd;
    addr[u]    = 16'($urandom);
    exp_rdy[u] = 1'b1;
    exp_drv[u] = 1'b0;
    for (int m = 1; m < 64; m++) begin
      @(posedge clk); #1;
      if (m == lw + 1) begin
        if (is_rd) exp_val[u] = in_rng ? mem_m[u][a[4:0]] : 16'h0000;
        else if (in_rng) mem_m[u][a[4:0]] = wd;
        if (!in_rng) exp_err[u] = 1'b1;
      end
      exp_rdy[u] = (m >= lw + 1);
      exp_drv[u] = is_rd && (m >= lw + 1);
      if (rdy[u]) begin
        if (lat < 0) lat = m - 1;
      end else begin
        low_cnt++;
      end
      if (m == lw + 1) got = bus_of(u);
      if (m == 1) begin
        addr[u] = a;
        if (!is_rd) begin
          drv_en[u]  = 1'b1;
          drv_val[u] = wd;
        end
      end
      if (m == abort_m) begin
        cs[u]     = 1'b0;
        drv_en[u] = 1'b0;
        @(posedge clk); #1;
        exp_rdy[u] = 1'b1;
        return;
      end
      if (rst_acc && m == lw) begin
        rst_v[u] = 1'b1;
        @(posedge clk); #1;
        rst_v[u]   = 1'b0;
        cs[u]      = 1'b0;
        drv_en[u]  = 1'b0;
        exp_rdy[u] = 1'b1;
        exp_err[u] = 1'b0;
        exp_drv[u] = 1'b0;
        return;
      end
      if (m == lw + 1 + hold_n) begin
        cs[u]      = 1'b0;
        drv_en[u]  = 1'b0;
        exp_drv[u] = 1'b0;
        return;
      end
    end
    check("txn_timeout", 16'(cs[u]), 16'h0000);
    cs[u]     = 1'b0;
    drv_en[u] = 1'b0;
  endtask

  initial begin
    logic [15:0] got, a, wd;
    int          lat, low, u, lw, r, abort_m, hold_n;
    bit          is_rd, rst_acc;
    for (int i = 0; i < 2; i++) begin
      cs[i]      = 1'b0;
      rd[i]      = 1'b0;
      addr[i]    = 16'h0000;
      drv_en[i]  = 1'b0;
      drv_val[i] = 16'h0000;
      rst_v[i]   = 1'b1;
      exp_rdy[i] = 1'b1;
      exp_err[i] = 1'b0;
      exp_drv[i] = 1'b0;
      exp_val[i] = 16'h0000;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    check("reset_ready", 16'(rdy[0]), 16'h0001);
    check("reset_err", 16'(errv[0]), 16'h0000);
    check("reset_bus_z", bus_a, 16'hFFFF);

    // Preload a known image into the first 32 words of both arrays.
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 32; w++) begin
        wd = 16'($urandom);
        if (w == 0) wd = 16'h0F0F;
        if (w == 1) wd = 16'h1111;
        if (w == 2) wd = 16'h2222;
        if (w == 5) wd = 16'h1234;
        if (w == 7) wd = 16'h7777;
        txn(i, 1'b0, 16'(w), wd, -1, 1'b0, 1, got, lat, low);
      end
    end

    txn(0, 1'b0, 16'h0010, 16'hA5C3, -1, 1'b0, 2, got, lat, low);
    check("write_ready_low_cycles", 16'(low), 16'd4);
    txn(0, 1'b1, 16'h0010, 16'h0000, -1, 1'b0, 2, got, lat, low);
    check("read_back_a5c3", got, 16'hA5C3);
    check("read_latency_w2", 16'(lat), 16'd4);

    txn(0, 1'b0, 16'h0400, 16'hFFFF, -1, 1'b0, 1, got, lat, low);
    check("oor_write_err", 16'(errv[0]), 16'h0001);
    txn(0, 1'b1, 16'h0000, 16'h0000, -1, 1'b0, 1, got, lat, low);
    check("oor_mem0_kept", got, 16'h0F0F);
    txn(0, 1'b1, 16'h0400, 16'h0000, -1, 1'b0, 1, got, lat, low);
    check("oor_read_zero", got, 16'h0000);

    txn(0, 1'b0, 16'h0005, 16'hDEAD, 2, 1'b0, 1, got, lat, low);
    check("abort_ready", 16'(rdy[0]), 16'h0001);
    txn(0, 1'b1, 16'h0005, 16'h0000, -1, 1'b0, 1, got, lat, low);
    check("abort_mem5_kept", got, 16'h1234);

    txn(0, 1'b0, 16'h0007, 16'hBEEF, -1, 1'b1, 1, got, lat, low);
    check("rst_access_err", 16'(errv[0]), 16'h0000);
    check("rst_access_ready", 16'(rdy[0]), 16'h0001);
    txn(0, 1'b1, 16'h0007, 16'h0000, -1, 1'b0, 1, got, lat, low);
    check("rst_access_mem7_kept", got, 16'h7777);

    txn(0, 1'b1, 16'h0001, 16'h0000, -1, 1'b0, 1, got, lat, low);
    check("b2b_read1", got, 16'h1111);
    txn(0, 1'b1, 16'h0002, 16'h0000, -1, 1'b0, 1, got, lat, low);
    check("b2b_read2", got, 16'h2222);

    txn(1, 1'b1, 16'h0001, 16'h0000, -1, 1'b0, 1, got, lat, low);
    check("read_latency_w0", 16'(lat), 16'd2);
    check("read_w0_data", got, 16'h1111);

    for (int n = 0; n < 200; n++) begin
      u       = int'($urandom_range(0, 1));
      is_rd   = 1'($urandom_range(0, 1));
      a       = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1024, 65535))
                                            : 16'($urandom_range(0, 31));
      wd      = 16'($urandom);
      r       = int'($urandom_range(0, 99));
      lw      = (u == 0) ? 4 : 2;
      abort_m = (r < 6) ? int'($urandom_range(1, lw - 1)) : -1;
      rst_acc = (r >= 6 && r < 9);
      hold_n  = int'($urandom_range(1, 3));
      txn(u, is_rd, a, wd, abort_m, rst_acc, hold_n, got, lat, low);
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
